// File: rtl/conv_encoder_stream.sv
// Rate-1/3 tail-biting convolutional encoder (K=7, generators 133/171/165 octal),
// DW bits per clock with valid/ready handshakes on input and output.
module conv_encoder_stream #(
  parameter int DW      = 8,
  parameter int MAX_LEN = 6144,
  parameter int MIN_LEN = 40,
  parameter int LEN_W   = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] blk_len,
  input  logic [5:0]       tail_bits,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_d0,
  output logic [DW-1:0]    out_d1,
  output logic [DW-1:0]    out_d2,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             err_len
);

  localparam int SHIFT = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENC   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [5:0]       s_reg;
  logic [LEN_W-1:0] words_left_reg;
  logic             out_valid_reg;
  logic [DW-1:0]    d0_reg;
  logic [DW-1:0]    d1_reg;
  logic [DW-1:0]    d2_reg;
  logic             err_len_reg;

  logic             len_ok;
  logic             load;
  logic             accept;
  logic [5:0]       s_next;
  logic [DW-1:0]    enc_d0;
  logic [DW-1:0]    enc_d1;
  logic [DW-1:0]    enc_d2;

  // Block length must be in range and a whole number of words.
  assign len_ok = (blk_len >= LEN_W'(MIN_LEN)) &&
                  (blk_len <= LEN_W'(MAX_LEN)) &&
                  ((blk_len & LEN_W'(DW - 1)) == '0);

  assign accept = in_valid && in_ready;

  // Bit-serial encoder unrolled across the word; s[0] is the most recent bit.
  always_comb begin
    logic [5:0] s;
    logic       c;
    s      = s_reg;
    c      = 1'b0;
    enc_d0 = '0;
    enc_d1 = '0;
    enc_d2 = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      c         = in_data[i];
      enc_d0[i] = c ^ s[1] ^ s[2] ^ s[4] ^ s[5];
      enc_d1[i] = c ^ s[0] ^ s[1] ^ s[2] ^ s[5];
      enc_d2[i] = c ^ s[0] ^ s[1] ^ s[3] ^ s[5];
      s         = {s[4:0], c};
    end
    s_next = s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && len_ok) begin
          load       = 1'b1;
          state_next = ENC;
        end
      end
      ENC: begin
        in_ready = !out_valid_reg || out_ready;
        if (in_valid && in_ready && (words_left_reg == LEN_W'(1))) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (out_valid_reg && out_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_reg          <= '0;
      words_left_reg <= '0;
      out_valid_reg  <= 1'b0;
      d0_reg         <= '0;
      d1_reg         <= '0;
      d2_reg         <= '0;
      err_len_reg    <= 1'b0;
    end else begin
      err_len_reg <= (state_reg == IDLE) && start && !len_ok;
      if (load) begin
        s_reg          <= tail_bits;
        words_left_reg <= blk_len >> SHIFT;
      end
      // A word leaving in the same cycle a new one arrives is simply overwritten.
      if (accept) begin
        s_reg          <= s_next;
        words_left_reg <= words_left_reg - LEN_W'(1);
        d0_reg         <= enc_d0;
        d1_reg         <= enc_d1;
        d2_reg         <= enc_d2;
        out_valid_reg  <= 1'b1;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg  <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_d0    = d0_reg;
  assign out_d1    = d1_reg;
  assign out_d2    = d2_reg;
  assign err_len   = err_len_reg;
  assign busy      = (state_reg != IDLE);

endmodule
